// File: rtl/mul.sv
// Two-stage signed 8x8 radix-4 Booth multiplier.
// Takes one operand pair per clock; the product is truncated to 15 bits.
module mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic        i_valid,
    output logic [14:0] o_mul,
    output logic        o_valid
);

    logic [7:0]  x_q;
    logic [7:0]  y_q;
    logic        v_q;
    logic [8:0]  y_ext;
    logic [14:0] x_ext;
    logic [14:0] sum;

    function automatic logic [14:0] booth_pp(
        input logic [2:0]  trip,
        input logic [14:0] xe
    );
        logic [14:0] pp;
        pp = '0;
        unique case (trip)
            3'b000, 3'b111: pp = '0;
            3'b001, 3'b010: pp = xe;
            3'b011:         pp = xe << 1;
            3'b100:         pp = ~(xe << 1) + 15'd1;
            3'b101, 3'b110: pp = ~xe + 15'd1;
        endcase
        return pp;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            x_q <= x;
            y_q <= y;
            v_q <= i_valid;
        end
    end

    // Implicit y[-1] = 0 makes triplet i simply y_ext[2i+2:2i].
    assign y_ext = {y_q, 1'b0};
    assign x_ext = {{7{x_q[7]}}, x_q};

    always_comb begin
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum = sum + (booth_pp(y_ext[2*i +: 3], x_ext) << (2 * i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_mul   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_mul   <= sum;
            o_valid <= v_q;
        end
    end

endmodule

// File: tb/tb_mul.sv
// Directed, random and exhaustive checks of the mul pipeline.
// Expected products come from hand tables or a behavioural model.
module tb_mul;

    logic        clk;
    logic        rst_n;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        i_valid;
    logic [14:0] o_mul;
    logic        o_valid;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        v;
        logic [14:0] e;
    } vec_t;

    vec_t q[$];

    mul dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .x      (x),
        .y      (y),
        .i_valid(i_valid),
        .o_mul  (o_mul),
        .o_valid(o_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] ref_mul(input logic [7:0] a,
                                            input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return p[14:0];
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [14:0] act, input logic [14:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] a, input logic [7:0] b,
                       input logic v, input logic [14:0] e);
        vec_t t;
        t.x = a;
        t.y = b;
        t.v = v;
        t.e = e;
        q.push_back(t);
    endtask

    // Streams q back-to-back; each result is checked two edges later.
    task automatic run_stream(input string name);
        int n;
        n = q.size();
        for (int k = 0; k < n + 2; k++) begin
            @(posedge clk);
            #1;
            if (k >= 2) begin
                chk({name, "_valid"}, k - 2, {14'd0, o_valid},
                    {14'd0, q[k-2].v});
                chk({name, "_mul"}, k - 2, o_mul, q[k-2].e);
            end
            if (k < n) begin
                x       = q[k].x;
                y       = q[k].y;
                i_valid = q[k].v;
            end else begin
                x       = '0;
                y       = '0;
                i_valid = 1'b0;
            end
        end
        q.delete();
    endtask

    initial begin
        rst_n   = 1'b0;
        x       = 8'h5A;
        y       = 8'h03;
        i_valid = 1'b1;
        #3;
        chk("rst_mul", 0, o_mul, 15'd0);
        chk("rst_valid", 0, {14'd0, o_valid}, 15'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_mul", 0, o_mul, 15'd0);
        chk("rst_hold_valid", 0, {14'd0, o_valid}, 15'd0);
        i_valid = 1'b0;
        #4;
        rst_n = 1'b1;

        // Hand-computed directed vectors
        add(8'd1,   8'd1,   1'b1, 15'd1);
        add(8'd2,   8'd2,   1'b1, 15'd4);
        add(8'd8,   8'd3,   1'b1, 15'd24);
        add(8'd15,  8'd15,  1'b1, 15'd225);
        add(8'd56,  8'd25,  1'b1, 15'd1400);
        add(8'hFD,  8'd7,   1'b1, 15'h7FEB);
        add(8'h7F,  8'h80,  1'b1, 15'h4080);
        add(8'h80,  8'h80,  1'b1, 15'h4000);
        add(8'hFF,  8'hFF,  1'b1, 15'h0001);
        add(8'h7F,  8'h7F,  1'b1, 15'h3F01);
        add(8'h9C,  8'h64,  1'b1, 15'h58F0);
        add(8'h00,  8'h55,  1'b1, 15'd0);
        add(8'h55,  8'h00,  1'b1, 15'd0);
        add(8'd3,   8'd4,   1'b1, 15'd12);
        add(8'd5,   8'd6,   1'b0, 15'd30);
        add(8'd7,   8'd8,   1'b1, 15'd56);
        run_stream("dir");

        for (int i = 0; i < 8; i++) begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            add(a, b, 1'b1, ref_mul(a, b));
        end
        run_stream("rnd");

        // Reset with pairs in flight must flush everything at once
        @(posedge clk);
        #1;
        x = 8'd5;
        y = 8'd5;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        x = 8'd3;
        y = 8'd3;
        @(posedge clk);
        #1;
        x = 8'd7;
        y = 8'd7;
        #2;
        chk("pre_rst_mul", 0, o_mul, 15'd25);
        chk("pre_rst_valid", 0, {14'd0, o_valid}, 15'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_mul", 0, o_mul, 15'd0);
        chk("async_rst_valid", 0, {14'd0, o_valid}, 15'd0);
        x = '0;
        y = '0;
        i_valid = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("flush_mul", i, o_mul, 15'd0);
            chk("flush_valid", i, {14'd0, o_valid}, 15'd0);
        end

        add(8'hF6, 8'd9, 1'b1, 15'h7FA6);
        run_stream("post_rst");

        for (int i = 0; i < 65536; i++) begin
            logic [15:0] p;
            p = 16'(i);
            add(p[15:8], p[7:0], 1'b1, ref_mul(p[15:8], p[7:0]));
        end
        run_stream("exh");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
